controle_pontuacao: RTL

Sequencer for the `calculadora_pontos` score datapath. It counts error pulses during each round and fires one `calcular` pulse per completed round, carrying the round index and that round's error count. After a fixed latency it captures the calculator's result as the running score. At game end it updates a persistent high score, so the game FSM sees a single round-done/game-done handshake instead of driving the calculator directly.

---
 rtl/controle_pontuacao_if.sv | 28 ++
 rtl/controle_pontuacao.sv | 98 +++++++++
 2 files changed

// File: rtl/controle_pontuacao_if.sv
// controle_pontuacao_if: bus between the game FSM and the score sequencer,
// including the calculator trigger/result lines.
interface controle_pontuacao_if;
    logic       iniciar;
    logic       erro;
    logic       fim_rodada;
    logic       fim_jogo;
    logic [7:0] pontos_calc;
    logic       calcular;
    logic [3:0] rodada;
    logic [7:0] erros;
    logic [7:0] pontos;
    logic [7:0] recorde;
    logic       novo_recorde;
    logic       pronto;
    logic       ocupado;
    logic       fim;

    modport master (
        output iniciar, erro, fim_rodada, fim_jogo, pontos_calc,
        input  calcular, rodada, erros, pontos, recorde, novo_recorde, pronto, ocupado, fim
    );

    modport slave (
        input  iniciar, erro, fim_rodada, fim_jogo, pontos_calc,
        output calcular, rodada, erros, pontos, recorde, novo_recorde, pronto, ocupado, fim
    );
endinterface

// File: rtl/controle_pontuacao.sv
// controle_pontuacao: per-round error counting, calculator triggering with fixed
// latency capture of the score, and persistent high-score tracking.
module controle_pontuacao #(
    parameter int LATENCIA = 2
) (
    input logic                  clock,
    input logic                  reset,
    controle_pontuacao_if.slave  bus
);
    typedef enum logic [2:0] {OCIOSO, ESPERA, DISPARA, AGUARDA, REGISTRA, FIM} estado_t;

    estado_t    r_estado, w_prox;
    logic [3:0] r_cnt, r_rodada;
    logic [7:0] r_erros, r_pontos, r_recorde;
    logic       r_novo, r_pronto, r_pend, r_entrada;
    logic       w_ocupado;

    assign w_ocupado        = r_estado == DISPARA || r_estado == AGUARDA || r_estado == REGISTRA;
    assign bus.calcular     = r_estado == DISPARA;
    assign bus.ocupado      = w_ocupado;
    assign bus.fim          = r_estado == FIM;
    assign bus.rodada       = r_rodada;
    assign bus.erros        = r_erros;
    assign bus.pontos       = r_pontos;
    assign bus.recorde      = r_recorde;
    assign bus.novo_recorde = r_novo;
    assign bus.pronto       = r_pronto;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_estado <= OCIOSO;
        else       r_estado <= w_prox;
    end

    // AGUARDA leaves when the post-decrement count reaches 1
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO, FIM: w_prox = bus.iniciar ? ESPERA : r_estado;
            ESPERA:      w_prox = bus.fim_rodada ? DISPARA : bus.fim_jogo ? FIM : ESPERA;
            DISPARA:     w_prox = (LATENCIA == 1) ? REGISTRA : AGUARDA;
            AGUARDA:     w_prox = (r_cnt <= 4'd2) ? REGISTRA : AGUARDA;
            REGISTRA:    w_prox = (r_pend || bus.fim_jogo || r_rodada == 4'd15) ? FIM : ESPERA;
            default:     w_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_rodada  <= '0;
            r_erros   <= '0;
            r_pontos  <= '0;
            r_recorde <= '0;
            r_novo    <= 1'b0;
            r_pronto  <= 1'b0;
            r_pend    <= 1'b0;
            r_entrada <= 1'b0;
        end else begin
            r_pronto  <= 1'b0;
            r_entrada <= w_prox == FIM && r_estado != FIM;
            case (r_estado)
                OCIOSO, FIM: begin
                    if (r_entrada && r_pontos > r_recorde) begin
                        r_recorde <= r_pontos;
                        r_novo    <= 1'b1;
                    end
                    if (bus.iniciar) begin
                        r_pontos <= '0;
                        r_rodada <= '0;
                        r_erros  <= '0;
                        r_novo   <= 1'b0;
                        r_pend   <= 1'b0;
                    end
                end
                ESPERA: begin
                    if (bus.erro && r_erros != 8'hFF) r_erros <= r_erros + 8'd1;
                    if (bus.fim_jogo && bus.fim_rodada) r_pend <= 1'b1;
                end
                DISPARA: begin
                    r_cnt <= 4'(LATENCIA);
                    if (bus.fim_jogo) r_pend <= 1'b1;
                end
                AGUARDA: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (bus.fim_jogo) r_pend <= 1'b1;
                end
                REGISTRA: begin
                    r_pontos <= bus.pontos_calc;
                    r_pronto <= 1'b1;
                    r_erros  <= '0;
                    if (bus.fim_jogo) r_pend <= 1'b1;
                    if (w_prox == ESPERA) r_rodada <= r_rodada + 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
